// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU writeback requests round-robin and
// drives the register-file demux select/enable and write data from registers.
module wb_arbiter #(
  parameter  int NUM_REGS   = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_valid,
  input  logic [IDX_W-1:0]      i_alu_rd,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [IDX_W-1:0]      i_lsu_rd,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  output logic                  o_lsu_ready,
  input  logic                  i_hold,
  output logic [IDX_W-1:0]      o_wb_select,
  output logic                  o_wb_enable,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic                  o_last_src
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  src_t r_prio;

  logic                  r_wb_enable;
  logic [IDX_W-1:0]      r_wb_select;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_last_src;

  logic w_grant_ok;
  logic w_alu_grant;
  logic w_lsu_grant;

  // A lone requester always wins; under contention the priority pointer decides.
  // Reset and hold both suppress every grant so no transfer can slip through.
  always_comb begin
    w_grant_ok  = !i_rst && !i_hold;
    w_alu_grant = w_grant_ok && i_alu_valid && (!i_lsu_valid || (r_prio == SRC_ALU));
    w_lsu_grant = w_grant_ok && i_lsu_valid && (!i_alu_valid || (r_prio == SRC_LSU));
  end

  assign o_alu_ready = w_alu_grant;
  assign o_lsu_ready = w_lsu_grant;

  // x0 writes are accepted and recorded but never strobed into the register file.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio      <= SRC_ALU;
      r_wb_enable <= 1'b0;
      r_wb_select <= '0;
      r_wb_data   <= '0;
      r_last_src  <= 1'b0;
    end else begin
      r_wb_enable <= 1'b0;
      if (w_alu_grant) begin
        r_wb_enable <= (i_alu_rd != '0);
        r_wb_select <= i_alu_rd;
        r_wb_data   <= i_alu_data;
        r_last_src  <= 1'b0;
        r_prio      <= SRC_LSU;
      end else if (w_lsu_grant) begin
        r_wb_enable <= (i_lsu_rd != '0);
        r_wb_select <= i_lsu_rd;
        r_wb_data   <= i_lsu_data;
        r_last_src  <= 1'b1;
        r_prio      <= SRC_ALU;
      end
    end
  end

  assign o_wb_enable = r_wb_enable;
  assign o_wb_select = r_wb_select;
  assign o_wb_data   = r_wb_data;
  assign o_last_src  = r_last_src;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter: vectors push the expected output
// stage contents, and a monitor compares them one cycle after each edge.
module tb_wb_arbiter;

  localparam int NUM_REGS   = 32;
  localparam int DATA_WIDTH = 32;
  localparam int IDX_W      = 5;

  logic                  clk;
  logic                  rst;
  logic                  aluValid;
  logic [IDX_W-1:0]      aluRd;
  logic [DATA_WIDTH-1:0] aluData;
  logic                  aluReady;
  logic                  lsuValid;
  logic [IDX_W-1:0]      lsuRd;
  logic [DATA_WIDTH-1:0] lsuData;
  logic                  lsuReady;
  logic                  hold;
  logic [IDX_W-1:0]      wbSelect;
  logic                  wbEnable;
  logic [DATA_WIDTH-1:0] wbData;
  logic                  lastSrc;

  typedef struct {
    int                    step;
    logic                  en;
    logic [IDX_W-1:0]      sel;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } expT;

  expT expQ[$];
  int  checkCount = 0;
  int  errorCount = 0;
  int  stepNum    = 0;

  wb_arbiter #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_alu_valid(aluValid),
    .i_alu_rd   (aluRd),
    .i_alu_data (aluData),
    .o_alu_ready(aluReady),
    .i_lsu_valid(lsuValid),
    .i_lsu_rd   (lsuRd),
    .i_lsu_data (lsuData),
    .o_lsu_ready(lsuReady),
    .i_hold     (hold),
    .o_wb_select(wbSelect),
    .o_wb_enable(wbEnable),
    .o_wb_data  (wbData),
    .o_last_src (lastSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL step %0d %s: got 0x%0h, expected 0x%0h", step, name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs before the edge, check the combinational readies,
  // and queue what the output stage must show after the edge.
  task automatic applyStimulus(
    input logic rstV, input logic aV, input logic [IDX_W-1:0] aR, input logic [31:0] aD,
    input logic lV, input logic [IDX_W-1:0] lR, input logic [31:0] lD, input logic holdV,
    input logic expAr, input logic expLr,
    input logic expEn, input logic [IDX_W-1:0] expSel, input logic [31:0] expData,
    input logic expLast);
    expT e;
    @(negedge clk);
    stepNum++;
    rst      = rstV;
    aluValid = aV;
    aluRd    = aR;
    aluData  = aD;
    lsuValid = lV;
    lsuRd    = lR;
    lsuData  = lD;
    hold     = holdV;
    #1;
    checkOutput("alu_ready", stepNum, 32'(aluReady), 32'(expAr));
    checkOutput("lsu_ready", stepNum, 32'(lsuReady), 32'(expLr));
    e.step = stepNum;
    e.en   = expEn;
    e.sel  = expSel;
    e.data = expData;
    e.last = expLast;
    expQ.push_back(e);
  endtask

  // Monitor: the output stage is presented every cycle, so each edge consumes one entry.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("wb_enable", e.step, 32'(wbEnable), 32'(e.en));
        checkOutput("wb_select", e.step, 32'(wbSelect), 32'(e.sel));
        checkOutput("wb_data",   e.step, wbData,         e.data);
        checkOutput("last_src",  e.step, 32'(lastSrc),  32'(e.last));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    aluValid = 1'b1;
    aluRd    = 5'd1;
    aluData  = 32'h11;
    lsuValid = 1'b1;
    lsuRd    = 5'd2;
    lsuData  = 32'h22;
    hold     = 1'b0;

    //            rst  aV   aRd   aData         lV   lRd   lData   hold  aRdy lRdy en   sel   data          last
    // Reset for two cycles with both sources requesting
    applyStimulus(1'b1,1'b1,5'd1, 32'h11,       1'b1,5'd2, 32'h22, 1'b0, 1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0);
    applyStimulus(1'b1,1'b1,5'd1, 32'h11,       1'b1,5'd2, 32'h22, 1'b0, 1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0);
    // Single ALU request
    applyStimulus(1'b0,1'b1,5'd5, 32'hDEADBEEF, 1'b0,5'd0, 32'h0,  1'b0, 1'b1,1'b0,1'b1,5'd5, 32'hDEADBEEF, 1'b0);
    // Back to reset, then contention ALU/LSU/ALU/LSU
    applyStimulus(1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,  1'b0, 1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0);
    applyStimulus(1'b0,1'b1,5'd1, 32'h11,       1'b1,5'd2, 32'h22, 1'b0, 1'b1,1'b0,1'b1,5'd1, 32'h11,       1'b0);
    applyStimulus(1'b0,1'b1,5'd1, 32'h11,       1'b1,5'd2, 32'h22, 1'b0, 1'b0,1'b1,1'b1,5'd2, 32'h22,       1'b1);
    applyStimulus(1'b0,1'b1,5'd1, 32'h11,       1'b1,5'd2, 32'h22, 1'b0, 1'b1,1'b0,1'b1,5'd1, 32'h11,       1'b0);
    applyStimulus(1'b0,1'b1,5'd1, 32'h11,       1'b1,5'd2, 32'h22, 1'b0, 1'b0,1'b1,1'b1,5'd2, 32'h22,       1'b1);
    // ALU grant moves priority to LSU, then an x0 LSU write moves it back to ALU
    applyStimulus(1'b0,1'b1,5'd3, 32'h33,       1'b0,5'd0, 32'h0,  1'b0, 1'b1,1'b0,1'b1,5'd3, 32'h33,       1'b0);
    applyStimulus(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd0, 32'h12, 1'b0, 1'b0,1'b1,1'b0,5'd0, 32'h12,       1'b1);
    // Hold for three cycles with both requesting
    applyStimulus(1'b0,1'b1,5'd4, 32'h44,       1'b1,5'd6, 32'h66, 1'b1, 1'b0,1'b0,1'b0,5'd0, 32'h12,       1'b1);
    applyStimulus(1'b0,1'b1,5'd4, 32'h44,       1'b1,5'd6, 32'h66, 1'b1, 1'b0,1'b0,1'b0,5'd0, 32'h12,       1'b1);
    applyStimulus(1'b0,1'b1,5'd4, 32'h44,       1'b1,5'd6, 32'h66, 1'b1, 1'b0,1'b0,1'b0,5'd0, 32'h12,       1'b1);
    // Release: pre-hold priority (ALU) wins first
    applyStimulus(1'b0,1'b1,5'd4, 32'h44,       1'b1,5'd6, 32'h66, 1'b0, 1'b1,1'b0,1'b1,5'd4, 32'h44,       1'b0);
    applyStimulus(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd6, 32'h66, 1'b0, 1'b0,1'b1,1'b1,5'd6, 32'h66,       1'b1);
    // Reset in the cycle an ALU write to r7 is requested
    applyStimulus(1'b1,1'b1,5'd7, 32'h77,       1'b0,5'd0, 32'h0,  1'b0, 1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0);
    applyStimulus(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,  1'b0, 1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0);
    // Same-rd collision: ALU then LSU, last grant's data remains
    applyStimulus(1'b0,1'b1,5'd9, 32'hA,        1'b1,5'd9, 32'hB,  1'b0, 1'b1,1'b0,1'b1,5'd9, 32'hA,        1'b0);
    applyStimulus(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd9, 32'hB,  1'b0, 1'b0,1'b1,1'b1,5'd9, 32'hB,        1'b1);
    applyStimulus(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,  1'b0, 1'b0,1'b0,1'b0,5'd9, 32'hB,        1'b1);

    @(posedge clk);
    #3;
    checkOutput("scoreboard_drained", stepNum, 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
